// File: rtl/div_sequencer_pkg.sv
// Shared types and constants for the divide sequencer and its sign helper.
package div_sequencer_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned COUNT_W = 4;

  localparam logic [DATA_W-1:0] DIV_ZERO_LO = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    WAIT = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation: used for operand magnitudes and result sign fix-up.
module div_sign_fix
  import div_sequencer_pkg::*;
(
  input  logic [DATA_W-1:0] value,
  input  logic              negate,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = value;
    if (negate) begin
      result = '0 - value;
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Sequencer wrapping an external unsigned divide core with signed pre/post processing.
// Optional feature: define DIV_ZERO_TRAP_EN to short-circuit zero divisors straight to DONE.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic              is_signed,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] core_a,
  output logic [DATA_W-1:0] core_b,
  input  logic [DATA_W-1:0] core_q,
  input  logic [DATA_W-1:0] core_r,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] hi,
  output logic              busy,
  output logic              done,
  output logic              dz
);

  localparam logic [COUNT_W-1:0] SETTLE_INIT = COUNT_W'(SETTLE_CYCLES - 1);

  state_t              state;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic                sgn;
  logic                a_sign;
  logic                b_sign;
  logic [COUNT_W-1:0]  count;

  logic [DATA_W-1:0]   mag_a;
  logic [DATA_W-1:0]   mag_b;
  logic [DATA_W-1:0]   fix_lo;
  logic [DATA_W-1:0]   fix_hi;

  // Truncating division: quotient sign is the XOR of operand signs, remainder follows the dividend.
  div_sign_fix u_abs_a (
    .value  (op_a),
    .negate (sgn & a_sign),
    .result (mag_a)
  );

  div_sign_fix u_abs_b (
    .value  (op_b),
    .negate (sgn & b_sign),
    .result (mag_b)
  );

  div_sign_fix u_fix_q (
    .value  (core_q),
    .negate (sgn & (a_sign ^ b_sign)),
    .result (fix_lo)
  );

  div_sign_fix u_fix_r (
    .value  (core_r),
    .negate (sgn & a_sign),
    .result (fix_hi)
  );

`ifndef DIV_ZERO_TRAP_EN
  assign dz = 1'b0;
`endif

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      sgn    <= 1'b0;
      a_sign <= 1'b0;
      b_sign <= 1'b0;
      count  <= '0;
      core_a <= '0;
      core_b <= '0;
      lo     <= '0;
      hi     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
      dz     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_a   <= dividend;
            op_b   <= divisor;
            sgn    <= is_signed;
            a_sign <= dividend[DATA_W-1];
            b_sign <= divisor[DATA_W-1];
`ifdef DIV_ZERO_TRAP_EN
            dz <= 1'b0;
            if (divisor == '0) begin
              lo    <= DIV_ZERO_LO;
              hi    <= dividend;
              dz    <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= LOAD;
            end
`else
            busy  <= 1'b1;
            state <= LOAD;
`endif
          end
        end
        LOAD: begin
          core_a <= mag_a;
          core_b <= mag_b;
          count  <= SETTLE_INIT;
          state  <= WAIT;
        end
        WAIT: begin
          if (count == '0) begin
            state <= FIX;
          end else begin
            count <= count - 1'b1;
          end
        end
        FIX: begin
          lo    <= fix_lo;
          hi    <= fix_hi;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer with a behavioural unsigned divide core.
module tb_div_sequencer;

  localparam int unsigned SETTLE = 4;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] core_a;
  logic [31:0] core_b;
  logic [31:0] core_q;
  logic [31:0] core_r;
  logic [31:0] lo;
  logic [31:0] hi;
  logic        busy;
  logic        done;
  logic        dz;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    int unsigned lat;
    int unsigned start_cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] last_lo = '0;
  logic [31:0] last_hi = '0;

  div_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .core_a    (core_a),
    .core_b    (core_b),
    .core_q    (core_q),
    .core_r    (core_r),
    .lo        (lo),
    .hi        (hi),
    .busy      (busy),
    .done      (done),
    .dz        (dz)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // External core: divide-by-zero returns all-ones quotient and the dividend as remainder.
  assign core_q = (core_b == '0) ? 32'hFFFF_FFFF : core_a / core_b;
  assign core_r = (core_b == '0) ? core_a : core_a % core_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic sg, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   sa;
    int   sd;
    e.dz  = 1'b0;
    e.lat = SETTLE + 3;
    e.start_cyc = 0;
    if (b == '0) begin
`ifdef DIV_ZERO_TRAP_EN
      e.lo  = 32'hFFFF_FFFF;
      e.hi  = a;
      e.dz  = 1'b1;
      e.lat = 1;
`else
      e.lo = 32'hFFFF_FFFF;
      e.hi = a;
`endif
    end else if (!sg) begin
      e.lo = a / b;
      e.hi = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.lo = 32'h8000_0000;
      e.hi = '0;
    end else begin
      sa   = a;
      sd   = b;
      e.lo = sa / sd;
      e.hi = sa % sd;
    end
    return e;
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", {31'b0, done}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("lo", lo, e.lo);
        check("hi", hi, e.hi);
        check("dz", {31'b0, dz}, {31'b0, e.dz});
        check("latency", cyc - e.start_cyc, e.lat);
        check("busy_with_done", {31'b0, busy}, 32'd0);
        last_lo = e.lo;
        last_hi = e.hi;
      end
    end
  end

  task automatic drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clock);
      n++;
    end
    repeat (2) @(negedge clock);
    check("drain", 32'(sb.size()), 32'd0);
    check("lo_hold", lo, last_lo);
    check("hi_hold", hi, last_hi);
    sb.delete();
  endtask

  task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(posedge clock);
    #1;
    is_signed = sg;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    e = model(sg, a, b);
    e.start_cyc = cyc;
    sb.push_back(e);
    @(posedge clock);
    #1;
    start = 1'b0;
    if (e.lat != 1) check("busy_load", {31'b0, busy}, 32'd1);
    drain();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_core_a"}, core_a, '0);
    check({tag, "_core_b"}, core_b, '0);
    check({tag, "_lo"}, lo, '0);
    check({tag, "_hi"}, hi, '0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_dz"}, {31'b0, dz}, 32'd0);
  endtask

  initial begin
    exp_t        e;
    int unsigned c0;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    clear = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    dividend = '0;
    divisor = '0;
    #1;
    check_cleared("reset");
    repeat (3) @(negedge clock);
    clear = 1'b0;

    run_op(1'b0, 32'd100, 32'd7);
    run_op(1'b1, -32'sd100, 32'd7);
    run_op(1'b1, 32'd100, -32'sd7);
    run_op(1'b1, -32'sd100, -32'sd7);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd2);
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(1'b0, 32'h0000_1234, 32'd0);
    run_op(1'b0, 32'd5, 32'd9);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      if (rb == '0) rb = 32'd3;
      rs = 1'($urandom_range(0, 1));
      run_op(rs, ra, rb);
    end

    // Mid-operation clear: abandon the divide, no done may follow.
    @(posedge clock);
    #1;
    is_signed = 1'b0;
    dividend  = 32'd50;
    divisor   = 32'd5;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    clear = 1'b1;
    #1;
    check_cleared("clear_wait");
    @(negedge clock);
    clear = 1'b0;
    last_lo = '0;
    last_hi = '0;
    repeat (SETTLE + 6) @(posedge clock);
    #1;
    check("clear_busy_after", {31'b0, busy}, 32'd0);
    run_op(1'b0, 32'd9, 32'd3);

    // Start held high: one accept every SETTLE+4 cycles.
    @(posedge clock);
    #1;
    is_signed = 1'b0;
    dividend  = 32'd1000;
    divisor   = 32'd33;
    start     = 1'b1;
    c0 = cyc;
    for (int unsigned k = 0; k * (SETTLE + 4) <= 19; k++) begin
      e = model(1'b0, 32'd1000, 32'd33);
      e.start_cyc = c0 + k * (SETTLE + 4);
      sb.push_back(e);
    end
    repeat (20) @(posedge clock);
    #1;
    start = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 The block SHALL have one parameter: SETTLE_CYCLES, default 4, meaning the number of cycles the combinational divide core is given to settle (legal range 1-15).
REQ-002 Port clock, input, 1, the sole clock; all state changes on its rising edge.
REQ-003 Port clear, input, 1, asynchronous active-high reset.
REQ-004 Port start, input, 1, request to begin a divide; sampled only in IDLE.
REQ-005 Port is_signed, input, 1, selects two's-complement (1) or unsigned (0) operation; sampled with start.
REQ-006 Port dividend, input, 32, dividend; sampled with start.
REQ-007 Port divisor, input, 32, divisor; sampled with start.
REQ-008 Port core_a, output, 32, registered unsigned dividend driven to the external unsigned divide core.
REQ-009 Port core_b, output, 32, registered unsigned divisor driven to the external unsigned divide core.
REQ-010 Port core_q, input, 32, unsigned quotient returned by the core.
REQ-011 Port core_r, input, 32, unsigned remainder returned by the core.
REQ-012 Port lo, output, 32, registered final quotient.
REQ-013 Port hi, output, 32, registered final remainder.
REQ-014 Port busy, output, 1, high while a divide is in progress.
REQ-015 Port done, output, 1, one-cycle pulse when lo and hi are valid.
REQ-016 Port dz, output, 1, divide-by-zero flag; valid with done.

Function
REQ-017 The state machine SHALL have states IDLE, LOAD, WAIT, FIX and DONE.
REQ-018 In IDLE with start=1, the block SHALL capture the operands, is_signed and the two sign bits, and go to LOAD.
REQ-019 In LOAD, core_a and core_b SHALL be loaded with the magnitudes (two's-complement negation of negative operands when is_signed=1, raw values otherwise); the settle counter SHALL load SETTLE_CYCLES-1; next state is WAIT.
REQ-020 In WAIT, the counter SHALL decrement each cycle; at count 0 the next state is FIX.
REQ-021 In FIX, lo and hi SHALL be registered from core_q and core_r with sign correction; next state is DONE.
- Quotient is negated when is_signed=1 and the operand signs differ.
- Remainder is negated when is_signed=1 and the dividend is negative (truncating division).
REQ-022 In DONE, done SHALL be 1 for exactly one cycle; next state is IDLE.
REQ-023 Latency from the start-sampling edge to done high SHALL be SETTLE_CYCLES+3 cycles.
REQ-024 busy SHALL be high in LOAD, WAIT and FIX, and low in IDLE and DONE.
REQ-025 start asserted outside IDLE SHALL be ignored; back-to-back start asserted in DONE is not accepted until IDLE.
REQ-026 Signed 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000 and hi=0, with no flag.
REQ-027 lo and hi SHALL hold their last values until the next FIX or DONE write.
REQ-028 All arithmetic SHALL be 32-bit modulo 2^32.

Reset
REQ-029 While clear=1, the block SHALL force state IDLE and set core_a, core_b, lo, hi, the counter, busy, done and dz to 0, including mid-operation; a divide in progress SHALL be abandoned without a done pulse.

Configuration
REQ-030 With DIV_ZERO_TRAP_EN defined, a zero divisor SHALL be detected in IDLE on start: the FSM goes directly to DONE, skipping LOAD, WAIT and FIX.
- Results: lo=0xFFFFFFFF, hi=dividend, dz=1 with done; latency is 1 cycle.
REQ-031 Without DIV_ZERO_TRAP_EN, a zero divisor SHALL run the normal sequence with the core's results, and dz SHALL be tied to 0.

Structure
REQ-032 A shared package SHALL hold the FSM state enumeration, the data width constant (32), and the DIV_ZERO_LO constant (0xFFFFFFFF).
REQ-033 A single sub-module, div_sign_fix (combinational magnitude and negation helper), SHALL be instantiated for operand abs and result fix-up.

Verification
REQ-034 Unsigned 100/7 -> lo=14, hi=2, done at cycle 7 with SETTLE_CYCLES=4.
REQ-035 Signed -100/7 -> lo=0xFFFFFFF2, hi=0xFFFFFFFE; signed 100/-7 -> lo=0xFFFFFFF2, hi=2.
REQ-036 Signed 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0; unsigned 0xFFFFFFFF/2 -> lo=0x7FFFFFFF, hi=1.
REQ-037 Divisor 0 with dividend 0x1234 under DIV_ZERO_TRAP_EN -> done after 1 cycle, lo=0xFFFFFFFF, hi=0x1234, dz=1.
REQ-038 clear pulsed during WAIT -> all outputs 0 and no done; a subsequent start of 9/3 -> lo=3, hi=0.
REQ-039 start held high for 20 cycles -> exactly one done every SETTLE_CYCLES+4 cycles, and busy never high together with done.
